// File: rtl/display_scan_4dig.sv
// Four-digit multiplexed display scanner for a common-anode module feeding DecoBin_7seg.
// Frame-synchronous value commit, per-slot dead time and optional leading-zero blanking.
module display_scan_4dig #(
    parameter int N_REFRESH  = 100000,
    parameter int N_DEADTIME = 1000
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic [15:0] i_Valor,
    input  logic        i_Load,
    input  logic        i_Supr_Ceros,
    output logic [3:0]  o_Digito,
    output logic [3:0]  o_Anodos,
    output logic        o_Listo,
    output logic        o_Frame
);
    localparam int CW = $clog2(N_REFRESH);
    localparam logic [CW-1:0] C_LAST      = CW'(N_REFRESH - 1);
    localparam logic [CW-1:0] C_DEAD_LAST = CW'(N_DEADTIME - 1);

    typedef enum logic {S_DEAD = 1'b0, S_ON = 1'b1} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [15:0]   r_display;
    logic [15:0]   r_pending;
    logic          r_listo;
    logic          r_frame;
    logic [3:0]    r_digito;
    logic [3:0]    r_anodos;

    logic          w_wrap;
    logic          w_commit;
    logic [1:0]    w_idx_nxt;
    logic [15:0]   w_src;
    logic          w_suppr;
    logic [3:0]    w_anodos_nxt;
    logic [3:0]    w_digito_nxt;

    assign w_wrap    = (r_cnt == C_LAST);
    assign w_commit  = w_wrap && (r_idx == 2'd3);
    assign w_idx_nxt = r_idx + 2'd1;
    // The digit loaded on the commit edge must come from the value being committed.
    assign w_src     = w_commit ? r_pending : r_display;

    // State register
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) r_state <= S_DEAD;
        else         r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_DEAD:  if (r_cnt == C_DEAD_LAST) w_state_nxt = S_ON;
            S_ON:    if (w_wrap)               w_state_nxt = S_DEAD;
            default: w_state_nxt = S_DEAD;
        endcase
    end

    always_comb begin
        w_suppr = 1'b0;
        case (r_idx)
            2'd1:    w_suppr = (r_display[15:4]  == 12'h000);
            2'd2:    w_suppr = (r_display[15:8]  == 8'h00);
            2'd3:    w_suppr = (r_display[15:12] == 4'h0);
            default: w_suppr = 1'b0;
        endcase
        w_suppr = w_suppr && i_Supr_Ceros;
    end

    // Output logic: the anode pattern is decided once at slot turn-on and then held.
    always_comb begin
        w_anodos_nxt = 4'b1111;
        if (w_state_nxt == S_ON) begin
            if (r_state == S_DEAD)
                w_anodos_nxt = w_suppr ? 4'b1111 : ~(4'b0001 << r_idx);
            else
                w_anodos_nxt = r_anodos;
        end
        w_digito_nxt = r_digito;
        if (w_wrap) begin
            case (w_idx_nxt)
                2'd0:    w_digito_nxt = w_src[3:0];
                2'd1:    w_digito_nxt = w_src[7:4];
                2'd2:    w_digito_nxt = w_src[11:8];
                default: w_digito_nxt = w_src[15:12];
            endcase
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_cnt     <= '0;
            r_idx     <= 2'd0;
            r_display <= 16'h0000;
            r_pending <= 16'h0000;
            r_listo   <= 1'b1;
            r_frame   <= 1'b0;
            r_digito  <= 4'h0;
            r_anodos  <= 4'b1111;
        end else begin
            r_cnt    <= w_wrap ? '0 : r_cnt + 1'b1;
            r_frame  <= w_commit;
            r_digito <= w_digito_nxt;
            r_anodos <= w_anodos_nxt;
            if (w_wrap)
                r_idx <= w_idx_nxt;
            if (w_commit)
                r_display <= r_pending;
            if (i_Load) begin
                r_pending <= i_Valor;
                r_listo   <= 1'b0;
            end else if (w_commit) begin
                r_listo   <= 1'b1;
            end
        end
    end

    assign o_Digito = r_digito;
    assign o_Anodos = r_anodos;
    assign o_Listo  = r_listo;
    assign o_Frame  = r_frame;
endmodule

// File: tb/tb_display_scan_4dig.sv
// Bench for display_scan_4dig with N_REFRESH=8, N_DEADTIME=2: per-cycle expected
// {frame, listo, anodes, digit} records are queued and compared by a negedge monitor.
module tb_display_scan_4dig;
    logic        clk;
    logic        rst;
    logic [15:0] valor;
    logic        load;
    logic        supr;
    logic [3:0]  digito;
    logic [3:0]  anodos;
    logic        listo;
    logic        frame;

    logic [9:0]  exp_q[$];
    logic        mon_en;
    int          cyc;
    int          mon_cnt;
    int          n_tests;
    int          n_fail;

    display_scan_4dig #(.N_REFRESH(8), .N_DEADTIME(2)) dut (
        .i_Clk       (clk),
        .i_Reset     (rst),
        .i_Valor     (valor),
        .i_Load      (load),
        .i_Supr_Ceros(supr),
        .o_Digito    (digito),
        .o_Anodos    (anodos),
        .o_Listo     (listo),
        .o_Frame     (frame)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected slot: 2 dead cycles at 1111, then the given anode pattern for 6;
    // listo is l0 before entry lchg and l1 from it on; frame only on entry 0.
    task automatic push_slot(input logic [3:0] an, input logic [3:0] dg, input logic fr,
                             input logic l0, input logic l1, input int lchg, input int n);
        for (int e = 0; e < n; e++) begin
            exp_q.push_back({(e == 0) ? fr : 1'b0, (e < lchg) ? l0 : l1,
                             (e < 2) ? 4'b1111 : an, dg});
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
        cyc += n;
    endtask

    task automatic do_load(input logic [15:0] v);
        valor = v;
        load  = 1'b1;
        adv(1);
        load  = 1'b0;
    endtask

    task automatic chk(input string name, input logic [9:0] got, input logic [9:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b expected=%b", name, got, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scan[%0d] expected queue empty, got fr=%b listo=%b an=%b dig=%h",
                         mon_cnt, frame, listo, anodos, digito);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({frame, listo, anodos, digito} !== e) begin
                    n_fail++;
                    $display("FAIL scan[%0d] got fr=%b listo=%b an=%b dig=%h expected fr=%b listo=%b an=%b dig=%h",
                             mon_cnt, frame, listo, anodos, digito, e[9], e[8], e[7:4], e[3:0]);
                end
            end
            mon_cnt++;
        end
    end

    initial begin
        rst = 1'b1; valor = 16'h0000; load = 1'b0; supr = 1'b0;
        mon_en = 1'b0; cyc = 0; mon_cnt = 0; n_tests = 0; n_fail = 0;
        repeat (3) @(posedge clk);

        // Frame 0: value 0, no suppression, load A3F5 sampled at cycle 5
        push_slot(4'b1110, 4'h0, 1'b0, 1'b1, 1'b0, 5, 8);
        push_slot(4'b1101, 4'h0, 1'b0, 1'b0, 1'b0, 8, 8);
        push_slot(4'b1011, 4'h0, 1'b0, 1'b0, 1'b0, 8, 8);
        push_slot(4'b0111, 4'h0, 1'b0, 1'b0, 1'b0, 8, 8);
        @(posedge clk); #1;
        rst = 1'b0; cyc = 0; mon_en = 1'b1;
        adv(4);
        do_load(16'hA3F5);
        adv(27);

        // Frame 1: A3F5; loads 1111 (cycle 42) then 2222 (cycle 50)
        push_slot(4'b1110, 4'h5, 1'b1, 1'b1, 1'b1, 8, 8);
        push_slot(4'b1101, 4'hF, 1'b0, 1'b1, 1'b0, 2, 8);
        push_slot(4'b1011, 4'h3, 1'b0, 1'b0, 1'b0, 8, 8);
        push_slot(4'b0111, 4'hA, 1'b0, 1'b0, 1'b0, 8, 8);
        adv(9);
        do_load(16'h1111);
        adv(7);
        do_load(16'h2222);
        adv(14);

        // Frame 2: 2222 only; load 0070 at cycle 70 with suppression on
        push_slot(4'b1110, 4'h2, 1'b1, 1'b1, 1'b0, 6, 8);
        push_slot(4'b1101, 4'h2, 1'b0, 1'b0, 1'b0, 8, 8);
        push_slot(4'b1011, 4'h2, 1'b0, 1'b0, 1'b0, 8, 8);
        push_slot(4'b0111, 4'h2, 1'b0, 1'b0, 1'b0, 8, 8);
        adv(5);
        supr = 1'b1;
        do_load(16'h0070);
        adv(26);

        // Frame 3: 0070 suppressed -> digits 3,2 dark; load 0000 at cycle 100
        push_slot(4'b1110, 4'h0, 1'b1, 1'b1, 1'b0, 4, 8);
        push_slot(4'b1101, 4'h7, 1'b0, 1'b0, 1'b0, 8, 8);
        push_slot(4'b1111, 4'h0, 1'b0, 1'b0, 1'b0, 8, 8);
        push_slot(4'b1111, 4'h0, 1'b0, 1'b0, 1'b0, 8, 8);
        adv(3);
        do_load(16'h0000);
        adv(28);

        // Frame 4: 0000 -> only digit 0 lit; load 1234 at cycle 140
        push_slot(4'b1110, 4'h0, 1'b1, 1'b1, 1'b1, 8, 8);
        push_slot(4'b1111, 4'h0, 1'b0, 1'b1, 1'b0, 4, 8);
        push_slot(4'b1111, 4'h0, 1'b0, 1'b0, 1'b0, 8, 8);
        push_slot(4'b1111, 4'h0, 1'b0, 1'b0, 1'b0, 8, 8);
        adv(11);
        do_load(16'h1234);
        adv(16);
        supr = 1'b0;
        adv(3);
        do_load(16'hBEEF);

        // Frame 5: BEEF loaded on the commit edge -> 1234 shown, listo stays 0
        push_slot(4'b1110, 4'h4, 1'b1, 1'b0, 1'b0, 8, 8);
        push_slot(4'b1101, 4'h3, 1'b0, 1'b0, 1'b0, 8, 8);
        push_slot(4'b1011, 4'h2, 1'b0, 1'b0, 1'b0, 8, 8);
        push_slot(4'b0111, 4'h1, 1'b0, 1'b0, 1'b0, 8, 8);
        adv(32);

        // Frame 6: BEEF; load 5555 at cycle 202; reset lands in digit 2's S_ON
        push_slot(4'b1110, 4'hF, 1'b1, 1'b1, 1'b1, 8, 8);
        push_slot(4'b1101, 4'hE, 1'b0, 1'b1, 1'b0, 2, 8);
        push_slot(4'b1011, 4'hE, 1'b0, 1'b0, 1'b0, 8, 5);
        adv(9);
        do_load(16'h5555);
        adv(10);
        #5;
        mon_en = 1'b0;
        chk("pre_reset_queue_drained", 10'(exp_q.size()), 10'd0);
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", {frame, listo, anodos, digito}, {1'b0, 1'b1, 4'b1111, 4'h0});

        // After release: pending discarded, two frames of zeros, second one with frame pulse
        @(posedge clk); #1;
        for (int f = 0; f < 2; f++) begin
            push_slot(4'b1110, 4'h0, (f == 1), 1'b1, 1'b1, 8, 8);
            push_slot(4'b1101, 4'h0, 1'b0,     1'b1, 1'b1, 8, 8);
            push_slot(4'b1011, 4'h0, 1'b0,     1'b1, 1'b1, 8, 8);
            push_slot(4'b0111, 4'h0, 1'b0,     1'b1, 1'b1, 8, 8);
        end
        rst = 1'b0; cyc = 0; mon_en = 1'b1;
        adv(64);
        mon_en = 1'b0;
        chk("final_queue_drained", 10'(exp_q.size()), 10'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
